// File: rtl/integ_dump_shifter_if.sv
// Sample-stream bundle for integ_dump_shifter.
// master = sample source side, slave = decimator side.
interface integ_dump_shifter_if #(
    parameter int BW     = 16,
    parameter int RATE_W = 10,
    parameter int NCH    = 2
);
    logic                enable;
    logic [RATE_W-1:0]   rate;
    logic                strobe_in;
    logic [NCH*BW-1:0]   signal_in;
    logic                strobe_out;
    logic [NCH*BW-1:0]   signal_out;
    logic [4:0]          shift;

    modport master (
        output enable, rate, strobe_in, signal_in,
        input  strobe_out, signal_out, shift
    );

    modport slave (
        input  enable, rate, strobe_in, signal_in,
        output strobe_out, signal_out, shift
    );
endinterface

// File: rtl/integ_dump_shifter.sv
// Multi-channel integrate-and-dump decimator, gain normalised by 2^ceil(log2(N)).
// Optional INTEG_ROUND_EN: round half toward +inf instead of floor truncation.
module integ_dump_shifter #(
    parameter int BW     = 16,
    parameter int RATE_W = 10,
    parameter int NCH    = 2
) (
    input logic                  clock,
    input logic                  reset_n,
    integ_dump_shifter_if.slave  bus
);
    localparam int ACC_W = BW + RATE_W;

    logic [RATE_W-1:0]       count;
    logic [RATE_W-1:0]       rate_q;
    logic [RATE_W-1:0]       r_eff;
    logic [4:0]              sh_eff;
    logic [4:0]              shift_q;
    logic                    dump;
    logic                    strobe_q;
    logic [NCH*BW-1:0]       out_q;
    logic [NCH*BW-1:0]       result;
    logic signed [BW-1:0]    smp;
    logic signed [ACC_W-1:0] acc [NCH];
    logic signed [ACC_W-1:0] sum [NCH];
`ifdef INTEG_ROUND_EN
    logic [ACC_W:0]          half;
    logic signed [ACC_W:0]   rsum;
`endif

    // ceil(log2(r+1)): smallest s with 2^s >= N
    function automatic logic [4:0] clog2n(input logic [RATE_W-1:0] r);
        logic [RATE_W:0] n;
        logic [4:0]      s;
        n = {1'b0, r} + 1'b1;
        s = '0;
        for (int i = 0; i < RATE_W; i++) begin
            if (n > ((RATE_W+1)'(1) << i)) s = 5'(i + 1);
        end
        return s;
    endfunction

    // First strobe of a period uses the live rate; the rest use the latched copy
    always_comb begin
        r_eff  = (count == '0) ? bus.rate : rate_q;
        dump   = bus.strobe_in && (count == r_eff);
        sh_eff = clog2n(r_eff);
        result = '0;
        smp    = '0;
`ifdef INTEG_ROUND_EN
        half   = '0;
        rsum   = '0;
        if (sh_eff != 5'd0) half = (ACC_W+1)'(1) << (sh_eff - 5'd1);
`endif
        for (int c = 0; c < NCH; c++) begin
            smp    = bus.signal_in[c*BW +: BW];
            sum[c] = acc[c] + ACC_W'(smp);
`ifdef INTEG_ROUND_EN
            rsum   = (ACC_W+1)'(sum[c]) + half;
            result[c*BW +: BW] = BW'(rsum >>> sh_eff);
`else
            result[c*BW +: BW] = BW'(sum[c] >>> sh_eff);
`endif
        end
    end

    // Period counter, accumulators, rate latch and registered output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            rate_q   <= '0;
            shift_q  <= '0;
            strobe_q <= 1'b0;
            out_q    <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (!bus.enable) begin
            count    <= '0;
            strobe_q <= 1'b0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
        end else begin
            strobe_q <= dump;
            if (bus.strobe_in) begin
                if (count == '0) begin
                    rate_q  <= bus.rate;
                    shift_q <= sh_eff;
                end
                if (dump) begin
                    count <= '0;
                    out_q <= result;
                    for (int c = 0; c < NCH; c++) acc[c] <= '0;
                end else begin
                    count <= count + 1'b1;
                    for (int c = 0; c < NCH; c++) acc[c] <= sum[c];
                end
            end
        end
    end

    assign bus.strobe_out = strobe_q;
    assign bus.signal_out = out_q;
    assign bus.shift      = shift_q;
endmodule

// File: tb/tb_integ_dump_shifter.sv
// Self-checking bench for integ_dump_shifter.
// Reference model: per-period running sums and integer floor/round division.
module tb_integ_dump_shifter;
    localparam int BW  = 16;
    localparam int RW  = 10;
    localparam int NCH = 2;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    integ_dump_shifter_if #(.BW(BW), .RATE_W(RW), .NCH(NCH)) bus ();

    integ_dump_shifter #(.BW(BW), .RATE_W(RW), .NCH(NCH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          m_cnt;
    int          m_n;
    int          m_shift;
    longint      m_sum [2];
    logic [15:0] m_out [2];
    logic        m_stb;

    function automatic int ceil_log2(input int n);
        int s;
        s = 0;
        while ((1 << s) < n) s++;
        return s;
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_n     = 1;
        m_shift = 0;
        m_stb   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_sum[c] = 0;
            m_out[c] = '0;
        end
    endtask

    // Apply one cycle of input, advance the model, land 1ns after the edge
    task automatic drive(input logic en, input int r, input logic stb,
                         input int s0, input int s1);
        longint smp [2];
        longint res;
        bus.enable    = en;
        bus.rate      = RW'(r);
        bus.strobe_in = stb;
        bus.signal_in = {16'(s1), 16'(s0)};
        smp[0] = s0;
        smp[1] = s1;
        @(posedge clock);
        m_stb = 1'b0;
        if (!en) begin
            m_cnt    = 0;
            m_sum[0] = 0;
            m_sum[1] = 0;
        end else if (stb) begin
            if (m_cnt == 0) begin
                m_n     = r + 1;
                m_shift = ceil_log2(m_n);
            end
            for (int c = 0; c < 2; c++) m_sum[c] += smp[c];
            m_cnt++;
            if (m_cnt == m_n) begin
                for (int c = 0; c < 2; c++) begin
                    res = m_sum[c];
`ifdef INTEG_ROUND_EN
                    if (m_shift > 0) res += longint'(1) <<< (m_shift - 1);
`endif
                    res = res >>> m_shift;
                    m_out[c] = res[15:0];
                    m_sum[c] = 0;
                end
                m_cnt = 0;
                m_stb = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.enable    = 1'b0;
        bus.rate      = '0;
        bus.strobe_in = 1'b0;
        bus.signal_in = '0;
        reset_n       = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (bus.strobe_out !== 1'b0) $display("FAIL reset_stb got %b want 0", bus.strobe_out);
        else n_pass++;
        n_checks++;
        if (bus.signal_out !== 32'h0) $display("FAIL reset_out got %h want 0", bus.signal_out);
        else n_pass++;
        n_checks++;
        if (bus.shift !== 5'd0) $display("FAIL reset_shift got %0d want 0", bus.shift);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [31:0] want;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 0, 1'b1, i, -5);
            want = {16'hfffb, 16'(i)};
            n_checks++;
            if (bus.strobe_out !== 1'b1 || bus.signal_out !== want || bus.shift !== 5'd0)
                $display("FAIL passthrough[%0d] got stb=%b out=%h sh=%0d want stb=1 out=%h sh=0",
                         i, bus.strobe_out, bus.signal_out, bus.shift, want);
            else n_pass++;
        end
        drive(1'b1, 0, 1'b0, 0, 0);
        n_checks++;
        if (bus.strobe_out !== 1'b0 || bus.signal_out !== {16'hfffb, 16'd9})
            $display("FAIL passthrough_gap got stb=%b out=%h want stb=0 out=fffb0009",
                     bus.strobe_out, bus.signal_out);
        else n_pass++;
    endtask

    task automatic test_rate3();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 3, 1'b1, 1000, -1000);
            if (bus.strobe_out === 1'b1) begin
                pulses++;
                n_checks++;
                if (bus.signal_out !== {16'(-1000), 16'd1000})
                    $display("FAIL rate3_out got %h want %h", bus.signal_out,
                             {16'(-1000), 16'd1000});
                else n_pass++;
            end
        end
        n_checks++;
        if (pulses != 4) $display("FAIL rate3_pulses got %0d want 4", pulses);
        else n_pass++;
        n_checks++;
        if (bus.shift !== 5'd2) $display("FAIL rate3_shift got %0d want 2", bus.shift);
        else n_pass++;
    endtask

    task automatic test_rate4();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4, 1'b1, 800, 800);
            n_checks++;
            if (bus.strobe_out !== ((i % 5) == 4))
                $display("FAIL rate4_stb[%0d] got %b want %b", i, bus.strobe_out, (i % 5) == 4);
            else n_pass++;
            if (bus.strobe_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 2 || bus.signal_out !== {16'd500, 16'd500} || bus.shift !== 5'd3)
            $display("FAIL rate4_out got n=%0d out=%h sh=%0d want n=2 out=01f401f4 sh=3",
                     pulses, bus.signal_out, bus.shift);
        else n_pass++;
    endtask

    task automatic test_rounding();
        logic [15:0] want_neg;
`ifdef INTEG_ROUND_EN
        want_neg = 16'hffff;
`else
        want_neg = 16'hfffe;
`endif
        drive(1'b1, 1, 1'b1, -1, 32767);
        drive(1'b1, 1, 1'b1, -2, 32767);
        n_checks++;
        if (bus.strobe_out !== 1'b1 || bus.signal_out !== {16'h7fff, want_neg})
            $display("FAIL round_out got stb=%b out=%h want stb=1 out=%h",
                     bus.strobe_out, bus.signal_out, {16'h7fff, want_neg});
        else n_pass++;
    endtask

    task automatic test_rate_change();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i < 3) ? 7 : 1, 1'b1, 100, 100);
            n_checks++;
            if (bus.strobe_out !== (i == 7))
                $display("FAIL ratechg_stb[%0d] got %b want %b", i, bus.strobe_out, i == 7);
            else n_pass++;
        end
        n_checks++;
        if (bus.signal_out !== {16'd100, 16'd100} || bus.shift !== 5'd3)
            $display("FAIL ratechg_first got out=%h sh=%0d want out=00640064 sh=3",
                     bus.signal_out, bus.shift);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 1'b1, (i % 2) ? 300 : 100, -100);
            if (bus.strobe_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 2 || bus.signal_out !== {16'(-100), 16'd200} || bus.shift !== 5'd1)
            $display("FAIL ratechg_n2 got n=%0d out=%h sh=%0d want n=2 out=%h sh=1",
                     pulses, bus.signal_out, bus.shift, {16'(-100), 16'd200});
        else n_pass++;
    endtask

    task automatic test_enable_flush();
        logic [31:0] held;
        drive(1'b1, 3, 1'b1, 9000, -9000);
        drive(1'b1, 3, 1'b1, 9000, -9000);
        drive(1'b0, 3, 1'b1, 9000, -9000);
        for (int i = 0; i < 4; i++) drive(1'b1, 3, 1'b1, 50, 50);
        n_checks++;
        if (bus.strobe_out !== 1'b1 || bus.signal_out !== {16'd50, 16'd50})
            $display("FAIL flush_out got stb=%b out=%h want stb=1 out=00320032",
                     bus.strobe_out, bus.signal_out);
        else n_pass++;
        held = bus.signal_out;
        drive(1'b1, 1, 1'b1, 7, 7);
        drive(1'b0, 1, 1'b1, 7, 7);
        n_checks++;
        if (bus.strobe_out !== 1'b0 || bus.signal_out !== held)
            $display("FAIL flush_dump got stb=%b out=%h want stb=0 out=%h",
                     bus.strobe_out, bus.signal_out, held);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3, 1'b1, 7000, 7000);
        drive(1'b1, 3, 1'b1, 7000, 7000);
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.strobe_out !== 1'b0 || bus.signal_out !== 32'h0 || bus.shift !== 5'd0)
            $display("FAIL midreset got stb=%b out=%h sh=%0d want 0/0/0",
                     bus.strobe_out, bus.signal_out, bus.shift);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 3, 1'b1, 50, -50);
        n_checks++;
        if (bus.strobe_out !== 1'b1 || bus.signal_out !== {16'(-50), 16'd50})
            $display("FAIL midreset_next got stb=%b out=%h want stb=1 out=%h",
                     bus.strobe_out, bus.signal_out, {16'(-50), 16'd50});
        else n_pass++;
    endtask

    task automatic test_max_rate();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, 1023, 1'b1, -32768, 32767);
            if (bus.strobe_out === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || bus.signal_out !== 32'h7fff8000 || bus.shift !== 5'd10)
            $display("FAIL maxrate got n=%0d out=%h sh=%0d want n=1 out=7fff8000 sh=10",
                     pulses, bus.signal_out, bus.shift);
        else n_pass++;
    endtask

    task automatic test_random();
        int    r;
        int    errs;
        logic  en;
        logic  stb;
        r    = 2;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r = $urandom_range(0, 15);
            en  = ($urandom_range(0, 99) != 0);
            stb = ($urandom_range(0, 9) < 7);
            drive(en, r, stb, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
            n_checks++;
            if (bus.strobe_out !== m_stb || bus.signal_out !== {m_out[1], m_out[0]} ||
                bus.shift !== 5'(m_shift)) begin
                errs++;
                if (errs < 10)
                    $display("FAIL random[%0d] got stb=%b out=%h sh=%0d want stb=%b out=%h sh=%0d",
                             i, bus.strobe_out, bus.signal_out, bus.shift,
                             m_stb, {m_out[1], m_out[0]}, m_shift);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rate3();
        test_rate4();
        test_rounding();
        test_rate_change();
        test_enable_flush();
        test_reset_mid();
        test_max_rate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
